// File: rtl/mode_switchboard_pkg.sv
// Shared defaults, issue-path action encoding and one-hot decode helper
// for the mode switchboard.
package mode_switchboard_pkg;

    localparam int DEF_NUM_CH = 3;
    localparam int DEF_DATA_W = 8;
    localparam int DEF_DROP_W = 8;
    localparam int MAX_CH     = 8;
    localparam int MAX_IDX_W  = 3;

    // What the issue path does with an accepted byte this cycle
    typedef enum logic [1:0] {
        ISS_NONE   = 2'd0,
        ISS_DIRECT = 2'd1,
        ISS_PEND   = 2'd2,
        ISS_DROP   = 2'd3
    } issue_act_e;

    function automatic logic [MAX_CH-1:0] onehot(input logic [MAX_IDX_W-1:0] idx);
        onehot = {{(MAX_CH-1){1'b0}}, 1'b1} << idx;
    endfunction

endpackage

// File: rtl/mode_switchboard_mode_sel.sv
// Mode selector: edge-detects step requests, defers the step while the
// issue path holds it off, wraps the index and decodes it one-hot.
// Optional feature macro: MODE_PREV_EN adds a backward-step input.
module mode_sel
    import mode_switchboard_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              sysclk,
    input  logic              reset,
    input  logic              mode_next,
`ifdef MODE_PREV_EN
    input  logic              mode_prev,
`endif
    input  logic              hold,
    output logic [IDX_W-1:0]  mode_idx,
    output logic [NUM_CH-1:0] active
);

    localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_CH - 1);

    logic             next_q;
    logic             next_rise;
    logic             req_next;
    logic             prev_rise;
    logic             req_prev;
    logic             step_take;
    logic [IDX_W-1:0] idx_nxt;

    assign next_rise = mode_next & ~next_q;

`ifdef MODE_PREV_EN
    logic prev_q;

    assign prev_rise = mode_prev & ~prev_q;

    // Backward request: set on an unmatched prev rise, consumed by a step
    always_ff @(posedge sysclk) begin
        if (reset) begin
            prev_q   <= 1'b0;
            req_prev <= 1'b0;
        end else begin
            prev_q <= mode_prev;
            if (step_take)
                req_prev <= 1'b0;
            else if (prev_rise && !next_rise)
                req_prev <= 1'b1;
        end
    end
`else
    assign prev_rise = 1'b0;
    assign req_prev  = 1'b0;
`endif

    // Steps wait until the issue path is quiet; simultaneous rises cancel
    assign step_take = (req_next | req_prev) & ~hold;

    // Forward request: coalesces repeated rises into a single step
    always_ff @(posedge sysclk) begin
        if (reset) begin
            next_q   <= 1'b0;
            req_next <= 1'b0;
        end else begin
            next_q <= mode_next;
            if (step_take)
                req_next <= 1'b0;
            else if (next_rise && !prev_rise)
                req_next <= 1'b1;
        end
    end

    // Next index with wrap in either direction; opposing requests cancel
    always_comb begin
        idx_nxt = mode_idx;
        if (step_take) begin
            if (req_next && !req_prev)
                idx_nxt = (mode_idx == LAST) ? '0 : mode_idx + IDX_W'(1);
            else if (req_prev && !req_next)
                idx_nxt = (mode_idx == '0) ? LAST : mode_idx - IDX_W'(1);
        end
    end

    // Active index register
    always_ff @(posedge sysclk) begin
        if (reset)
            mode_idx <= '0;
        else
            mode_idx <= idx_nxt;
    end

    assign active = NUM_CH'(onehot(MAX_IDX_W'(mode_idx)));

endmodule

// File: rtl/mode_switchboard.sv
// Mode switchboard top: routes the active channel's byte/start onto one
// serializer port with a one-deep pending buffer and a saturating drop
// counter. Optional feature macro: MODE_PREV_EN (backward mode step).
module mode_switchboard
    import mode_switchboard_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int DATA_W = DEF_DATA_W,
    parameter int DROP_W = DEF_DROP_W,
    parameter int IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     sysclk,
    input  logic                     reset,
    input  logic                     mode_next,
`ifdef MODE_PREV_EN
    input  logic                     mode_prev,
`endif
    input  logic [NUM_CH*DATA_W-1:0] ch_data,
    input  logic [NUM_CH-1:0]        ch_start,
    input  logic                     tx_busy,
    output logic [NUM_CH-1:0]        active,
    output logic [NUM_CH-1:0]        leds,
    output logic [IDX_W-1:0]         mode_idx,
    output logic [DATA_W-1:0]        out_data,
    output logic                     out_start,
    output logic [DROP_W-1:0]        drop_cnt
);

    logic [NUM_CH-1:0] start_q;
    logic              accept;
    logic [DATA_W-1:0] sel_byte;
    logic [DATA_W-1:0] pend_data;
    logic              pend_v;
    logic              idle;
    logic              drain;
    logic              hold;
    issue_act_e        act;

    // An accept also holds the selector so index change and accept never coincide
    assign hold = tx_busy | pend_v | out_start | accept;

    mode_sel #(
        .NUM_CH (NUM_CH),
        .IDX_W  (IDX_W)
    ) u_mode_sel (
        .sysclk    (sysclk),
        .reset     (reset),
        .mode_next (mode_next),
`ifdef MODE_PREV_EN
        .mode_prev (mode_prev),
`endif
        .hold      (hold),
        .mode_idx  (mode_idx),
        .active    (active)
    );

    assign leds = active;

    // All channels are tracked so a mode change never fakes a start edge
    assign accept   = ch_start[mode_idx] & ~start_q[mode_idx];
    assign sel_byte = ch_data[mode_idx*DATA_W +: DATA_W];

    // Serializer is free only once busy is low and no start is in flight
    assign idle  = ~tx_busy & ~out_start;
    assign drain = pend_v & idle;

    // Route an accepted byte: direct issue, park in pending, or drop
    always_comb begin
        act = ISS_NONE;
        if (accept) begin
            if (idle && !pend_v)
                act = ISS_DIRECT;
            else if (!pend_v || drain)
                act = ISS_PEND;
            else
                act = ISS_DROP;
        end
    end

    // Start edge history
    always_ff @(posedge sysclk) begin
        if (reset)
            start_q <= '0;
        else
            start_q <= ch_start;
    end

    // Output register, pending buffer and drop counter
    always_ff @(posedge sysclk) begin
        if (reset) begin
            out_data  <= '0;
            out_start <= 1'b0;
            pend_data <= '0;
            pend_v    <= 1'b0;
            drop_cnt  <= '0;
        end else begin
            out_start <= 1'b0;
            if (drain) begin
                out_data  <= pend_data;
                out_start <= 1'b1;
                pend_v    <= 1'b0;
            end
            case (act)
                ISS_DIRECT: begin
                    out_data  <= sel_byte;
                    out_start <= 1'b1;
                end
                ISS_PEND: begin
                    pend_data <= sel_byte;
                    pend_v    <= 1'b1;
                end
                ISS_DROP: begin
                    if (drop_cnt != '1)
                        drop_cnt <= drop_cnt + DROP_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mode_switchboard.sv
// Directed self-checking bench for mode_switchboard (default build and
// MODE_PREV_EN build). A second instance with DROP_W=2 shares all inputs.
module tb_mode_switchboard;

    logic        sysclk = 1'b0;
    logic        reset;
    logic        mode_next;
`ifdef MODE_PREV_EN
    logic        mode_prev;
`endif
    logic [23:0] ch_data;
    logic [2:0]  ch_start;
    logic        tx_busy;

    logic [2:0]  active, leds, active2, leds2;
    logic [1:0]  mode_idx, mode_idx2;
    logic [7:0]  out_data, out_data2;
    logic        out_start, out_start2;
    logic [7:0]  drop_cnt;
    logic [1:0]  drop_cnt2;

    int errors = 0;
    int checks = 0;

    always #5 sysclk = ~sysclk;

    mode_switchboard dut (
        .sysclk(sysclk), .reset(reset), .mode_next(mode_next),
`ifdef MODE_PREV_EN
        .mode_prev(mode_prev),
`endif
        .ch_data(ch_data), .ch_start(ch_start), .tx_busy(tx_busy),
        .active(active), .leds(leds), .mode_idx(mode_idx),
        .out_data(out_data), .out_start(out_start), .drop_cnt(drop_cnt)
    );

    mode_switchboard #(.DROP_W(2)) dut2 (
        .sysclk(sysclk), .reset(reset), .mode_next(mode_next),
`ifdef MODE_PREV_EN
        .mode_prev(mode_prev),
`endif
        .ch_data(ch_data), .ch_start(ch_start), .tx_busy(tx_busy),
        .active(active2), .leds(leds2), .mode_idx(mode_idx2),
        .out_data(out_data2), .out_start(out_start2), .drop_cnt(drop_cnt2)
    );

    task automatic tick();
        @(posedge sysclk);
        #1;
    endtask

    task automatic pulse_next();
        mode_next = 1'b1; tick();
        mode_next = 1'b0; tick();
    endtask

    task automatic test_reset();
        reset = 1'b1; mode_next = 1'b0; ch_data = '0; ch_start = '0; tx_busy = 1'b0;
`ifdef MODE_PREV_EN
        mode_prev = 1'b0;
`endif
        tick(); tick();
        reset = 1'b0;
        checks++; if (mode_idx !== 2'd0) begin errors++; $display("FAIL reset_idx got=%0d want=0", mode_idx); end
        checks++; if (active !== 3'b001) begin errors++; $display("FAIL reset_active got=%b want=001", active); end
        checks++; if (leds !== 3'b001) begin errors++; $display("FAIL reset_leds got=%b want=001", leds); end
        checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_data got=%h want=00", out_data); end
        checks++; if (out_start !== 1'b0) begin errors++; $display("FAIL reset_start got=%b want=0", out_start); end
        checks++; if (drop_cnt !== 8'd0) begin errors++; $display("FAIL reset_drop got=%0d want=0", drop_cnt); end
        checks++; if (drop_cnt2 !== 2'd0) begin errors++; $display("FAIL reset_drop2 got=%0d want=0", drop_cnt2); end
    endtask

    task automatic test_mode_cycle();
        logic [1:0] exp_idx [3] = '{2'd1, 2'd2, 2'd0};
        logic [2:0] exp_led [3] = '{3'b010, 3'b100, 3'b001};
        for (int i = 0; i < 3; i++) begin
            pulse_next();
            checks++; if (mode_idx !== exp_idx[i]) begin errors++; $display("FAIL cycle_idx[%0d] got=%0d want=%0d", i, mode_idx, exp_idx[i]); end
            checks++; if (leds !== exp_led[i]) begin errors++; $display("FAIL cycle_leds[%0d] got=%b want=%b", i, leds, exp_led[i]); end
        end
    endtask

    task automatic test_accept();
        pulse_next();
        ch_data = {8'h33, 8'hA5, 8'h5A};
        ch_start = 3'b010; tick();
        checks++; if (out_start !== 1'b1) begin errors++; $display("FAIL accept_start got=%b want=1", out_start); end
        checks++; if (out_data !== 8'hA5) begin errors++; $display("FAIL accept_data got=%h want=a5", out_data); end
        tick();
        checks++; if (out_start !== 1'b0) begin errors++; $display("FAIL accept_single got=%b want=0", out_start); end
        tick();
        checks++; if (out_start !== 1'b0) begin errors++; $display("FAIL accept_level got=%b want=0", out_start); end
        ch_start = 3'b000; tick();
        ch_start = 3'b001; tick();
        checks++; if (out_start !== 1'b0) begin errors++; $display("FAIL inactive_ch0 got=%b want=0", out_start); end
        ch_start = 3'b000; tick();
        ch_start = 3'b100; tick();
        checks++; if (out_start !== 1'b0) begin errors++; $display("FAIL inactive_ch2 got=%b want=0", out_start); end
        ch_start = 3'b000; tick();
        checks++; if (out_data !== 8'hA5) begin errors++; $display("FAIL inactive_data got=%h want=a5", out_data); end
        checks++; if (drop_cnt !== 8'd0) begin errors++; $display("FAIL inactive_drop got=%0d want=0", drop_cnt); end
    endtask

    task automatic test_pend_drop();
        logic [7:0] bytes [3] = '{8'h11, 8'h22, 8'h33};
        tx_busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ch_data[15:8] = bytes[i];
            ch_start = 3'b010; tick();
            ch_start = 3'b000; tick();
        end
        checks++; if (drop_cnt !== 8'd2) begin errors++; $display("FAIL pend_drop got=%0d want=2", drop_cnt); end
        checks++; if (drop_cnt2 !== 2'd2) begin errors++; $display("FAIL pend_drop2 got=%0d want=2", drop_cnt2); end
        checks++; if (out_start !== 1'b0) begin errors++; $display("FAIL pend_busy_start got=%b want=0", out_start); end
        tx_busy = 1'b0; tick();
        checks++; if (out_start !== 1'b1) begin errors++; $display("FAIL pend_drain_start got=%b want=1", out_start); end
        checks++; if (out_data !== 8'h11) begin errors++; $display("FAIL pend_drain_data got=%h want=11", out_data); end
        tx_busy = 1'b1; tick();
        checks++; if (out_start !== 1'b0) begin errors++; $display("FAIL pend_drain_single got=%b want=0", out_start); end
        tx_busy = 1'b0; tick();
        checks++; if (out_start !== 1'b0) begin errors++; $display("FAIL pend_empty got=%b want=0", out_start); end
    endtask

    task automatic test_back_to_back();
        tx_busy = 1'b1;
        ch_data[15:8] = 8'h44; ch_start = 3'b010; tick();
        ch_start = 3'b000; tick();
        tx_busy = 1'b0; ch_data[15:8] = 8'h55; ch_start = 3'b010; tick();
        checks++; if (out_start !== 1'b1) begin errors++; $display("FAIL b2b_first_start got=%b want=1", out_start); end
        checks++; if (out_data !== 8'h44) begin errors++; $display("FAIL b2b_first_data got=%h want=44", out_data); end
        tx_busy = 1'b1; ch_start = 3'b000; tick();
        checks++; if (out_start !== 1'b0) begin errors++; $display("FAIL b2b_gap got=%b want=0", out_start); end
        tx_busy = 1'b0; tick();
        checks++; if (out_start !== 1'b1) begin errors++; $display("FAIL b2b_second_start got=%b want=1", out_start); end
        checks++; if (out_data !== 8'h55) begin errors++; $display("FAIL b2b_second_data got=%h want=55", out_data); end
        checks++; if (drop_cnt !== 8'd2) begin errors++; $display("FAIL b2b_drop got=%0d want=2", drop_cnt); end
        tick();
    endtask

    task automatic test_mode_defer();
        tx_busy = 1'b1;
        pulse_next(); pulse_next();
        checks++; if (mode_idx !== 2'd1) begin errors++; $display("FAIL defer_busy_idx got=%0d want=1", mode_idx); end
        tx_busy = 1'b0; tick();
        checks++; if (mode_idx !== 2'd2) begin errors++; $display("FAIL defer_step_idx got=%0d want=2", mode_idx); end
        tick(); tick();
        checks++; if (mode_idx !== 2'd2) begin errors++; $display("FAIL defer_single_idx got=%0d want=2", mode_idx); end
        tx_busy = 1'b1;
        ch_data[23:16] = 8'h77; ch_start = 3'b100; tick();
        ch_start = 3'b000; tick();
        pulse_next();
        checks++; if (mode_idx !== 2'd2) begin errors++; $display("FAIL defer_pend_idx got=%0d want=2", mode_idx); end
        tx_busy = 1'b0; tick();
        checks++; if (out_data !== 8'h77) begin errors++; $display("FAIL defer_drain_data got=%h want=77", out_data); end
        checks++; if (mode_idx !== 2'd2) begin errors++; $display("FAIL defer_drain_idx got=%0d want=2", mode_idx); end
        tick();
        checks++; if (mode_idx !== 2'd2) begin errors++; $display("FAIL defer_ostart_idx got=%0d want=2", mode_idx); end
        tick();
        checks++; if (mode_idx !== 2'd0) begin errors++; $display("FAIL defer_final_idx got=%0d want=0", mode_idx); end
        checks++; if (leds !== 3'b001) begin errors++; $display("FAIL defer_final_leds got=%b want=001", leds); end
    endtask

    task automatic test_drop_sat();
        tx_busy = 1'b1;
        for (int i = 0; i < 6; i++) begin
            ch_data[7:0] = 8'h80 + 8'(i);
            ch_start = 3'b001; tick();
            ch_start = 3'b000; tick();
            checks++; if (drop_cnt !== 8'(2 + i)) begin errors++; $display("FAIL sat_drop[%0d] got=%0d want=%0d", i, drop_cnt, 2 + i); end
            checks++; if (drop_cnt2 !== ((i == 0) ? 2'd2 : 2'd3)) begin errors++; $display("FAIL sat_drop2[%0d] got=%0d want=%0d", i, drop_cnt2, (i == 0) ? 2 : 3); end
        end
        tx_busy = 1'b0; tick();
        checks++; if (out_data !== 8'h80) begin errors++; $display("FAIL sat_drain_data got=%h want=80", out_data); end
        tick();
    endtask

    task automatic test_reset_mid();
        tx_busy = 1'b1;
        ch_data[7:0] = 8'h99; ch_start = 3'b001; tick();
        ch_start = 3'b000; reset = 1'b1; tick();
        reset = 1'b0; tx_busy = 1'b0;
        checks++; if (drop_cnt !== 8'd0) begin errors++; $display("FAIL rmid_drop got=%0d want=0", drop_cnt); end
        checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL rmid_data got=%h want=00", out_data); end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (out_start !== 1'b0) begin errors++; $display("FAIL rmid_start[%0d] got=%b want=0", i, out_start); end
        end
    endtask

`ifdef MODE_PREV_EN
    task automatic test_prev();
        mode_prev = 1'b1; tick();
        mode_prev = 1'b0; tick();
        checks++; if (mode_idx !== 2'd2) begin errors++; $display("FAIL prev_wrap got=%0d want=2", mode_idx); end
        mode_next = 1'b1; mode_prev = 1'b1; tick();
        mode_next = 1'b0; mode_prev = 1'b0; tick(); tick();
        checks++; if (mode_idx !== 2'd2) begin errors++; $display("FAIL prev_cancel got=%0d want=2", mode_idx); end
        pulse_next();
        checks++; if (mode_idx !== 2'd0) begin errors++; $display("FAIL prev_then_next got=%0d want=0", mode_idx); end
    endtask
`endif

    initial begin
        test_reset();
        test_mode_cycle();
        test_accept();
        test_pend_drop();
        test_back_to_back();
        test_mode_defer();
        test_drop_sat();
        test_reset_mid();
`ifdef MODE_PREV_EN
        test_prev();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
